// File: rtl/serial_tx.sv
// rtl/serial_tx.sv - framed serial transmitter with optional even-parity bit
//
// Purpose:
//   Accepts a WIDTH-bit word through a VALID/READY handshake and sends it on
//   TX as: start bit (0), payload LSB first, optional even-parity bit, stop
//   bit (1). Each bit lasts BIT_CYCLES clock cycles. TX, READY and BUSY all
//   come straight from flops, so nothing on the input side reaches them
//   combinationally.
//
// Configuration:
//   SERIAL_TX_PARITY_EN - when defined, a PARITY state sends the XOR of all
//   payload bits between the last data bit and the stop bit. When undefined
//   the state and its logic do not exist and DATA goes straight to STOP.
//
// Ports:
//   C      in   1      clock, rising edge
//   R      in   1      synchronous active-high reset
//   DATA   in   WIDTH  parallel payload
//   VALID  in   1      DATA is valid
//   READY  out  1      word can be accepted (IDLE only)
//   TX     out  1      serial line, idle high
//   BUSY   out  1      frame on the line (always NOT READY)

module serial_tx #(
  parameter int WIDTH      = 8,
  parameter int BIT_CYCLES = 4
) (
  input  logic             C,
  input  logic             R,
  input  logic [WIDTH-1:0] DATA,
  input  logic             VALID,
  output logic             READY,
  output logic             TX,
  output logic             BUSY
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WIDTH - 1);
  localparam logic [7:0]       LAST_TICK = 8'(BIT_CYCLES - 1);

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;
`endif

  state_e           state_q, state_d;
  logic [7:0]       timer_q, timer_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             bit_done;
`ifdef SERIAL_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
`ifdef SERIAL_TX_PARITY_EN
    parity_d = parity_q;
`endif
    bit_done = (timer_q == LAST_TICK);

    // The bit timer runs whenever a frame is on the line and reloads at every
    // bit boundary, so each state lasts exactly BIT_CYCLES cycles.
    if (state_q != S_IDLE) begin
      timer_d = bit_done ? 8'd0 : timer_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (VALID) begin
          shift_d  = DATA;
`ifdef SERIAL_TX_PARITY_EN
          parity_d = ^DATA;
`endif
          timer_d  = 8'd0;
          idx_d    = '0;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (bit_done) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_done) begin
          // Shift right so the next payload bit is always at shift[0].
          shift_d = shift_q >> 1;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
`ifdef SERIAL_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: begin
        if (bit_done) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state and registered, so TX shows the
    // start bit in the cycle right after the accepting edge.
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge C) begin
    if (R) begin
      state_q  <= S_IDLE;
      timer_q  <= 8'd0;
      idx_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign TX    = tx_q;
  assign READY = ready_q;
  assign BUSY  = busy_q;

endmodule

// File: tb/tb_serial_tx.sv
// tb/tb_serial_tx.sv - directed self-checking bench for serial_tx

module tb_serial_tx;

`ifdef SERIAL_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB = 10 + P;

  logic       clk;
  logic       rst;
  logic [7:0] data_a;
  logic       valid_a;
  logic       ready_a, tx_a, busy_a;
  logic [3:0] data_b;
  logic       valid_b;
  logic       ready_b, tx_b, busy_b;

  int n_vec = 0;
  int n_err = 0;
  logic exp_bits [0:10];

  serial_tx #(.WIDTH(8), .BIT_CYCLES(4)) dut_a (
    .C(clk), .R(rst), .DATA(data_a), .VALID(valid_a),
    .READY(ready_a), .TX(tx_a), .BUSY(busy_a)
  );

  serial_tx #(.WIDTH(4), .BIT_CYCLES(1)) dut_b (
    .C(clk), .R(rst), .DATA(data_b), .VALID(valid_b),
    .READY(ready_b), .TX(tx_b), .BUSY(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; valid_a = 1'b0; data_a = 8'h00; valid_b = 1'b0; data_b = 4'h0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (tx_a !== 1'b1 || ready_a !== 1'b1 || busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL reset_a: tx=%b ready=%b busy=%b, required 1 1 0", tx_a, ready_a, busy_a);
    end
    n_vec++;
    if (tx_b !== 1'b1 || ready_b !== 1'b1 || busy_b !== 1'b0) begin
      n_err++;
      $display("FAIL reset_b: tx=%b ready=%b busy=%b, required 1 1 0", tx_b, ready_b, busy_b);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_frame_a5();
    if (P == 1) exp_bits = '{0,1,0,1,0,0,1,0,1,0,1};
    else        exp_bits = '{0,1,0,1,0,0,1,0,1,1,1};
    n_vec++;
    if (ready_a !== 1'b1) begin
      n_err++;
      $display("FAIL a5_ready_before: ready=%b, required 1", ready_a);
    end
    data_a = 8'hA5; valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    for (int b = 0; b < NB; b++) begin
      for (int c = 0; c < 4; c++) begin
        n_vec++;
        if (tx_a !== exp_bits[b] || ready_a !== 1'b0 || busy_a !== 1'b1) begin
          n_err++;
          $display("FAIL a5_bit%0d_cyc%0d: tx=%b ready=%b busy=%b, required tx=%b ready=0 busy=1",
                   b, c, tx_a, ready_a, busy_a, exp_bits[b]);
        end
        @(negedge clk);
      end
    end
    n_vec++;
    if (tx_a !== 1'b1 || ready_a !== 1'b1 || busy_a !== 1'b0) begin
      n_err++;
      $display("FAIL a5_end: tx=%b ready=%b busy=%b, required 1 1 0", tx_a, ready_a, busy_a);
    end
    @(negedge clk);
  endtask

  task automatic test_frame_07();
    if (P == 1) exp_bits = '{0,1,1,1,0,0,0,0,0,1,1};
    else        exp_bits = '{0,1,1,1,0,0,0,0,0,1,1};
    data_a = 8'h07; valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    for (int b = 0; b < NB; b++) begin
      for (int c = 0; c < 4; c++) begin
        n_vec++;
        if (tx_a !== exp_bits[b] || ready_a !== 1'b0) begin
          n_err++;
          $display("FAIL f07_bit%0d_cyc%0d: tx=%b ready=%b, required tx=%b ready=0",
                   b, c, tx_a, ready_a, exp_bits[b]);
        end
        @(negedge clk);
      end
    end
    n_vec++;
    if (tx_a !== 1'b1 || ready_a !== 1'b1) begin
      n_err++;
      $display("FAIL f07_end: tx=%b ready=%b, required 1 1", tx_a, ready_a);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    if (P == 1) exp_bits = '{0,1,0,0,0,0,0,0,0,1,1};
    else        exp_bits = '{0,1,0,0,0,0,0,0,0,1,1};
    data_a = 8'h01; valid_a = 1'b1;
    @(negedge clk);
    data_a = 8'hFF;
    for (int b = 0; b < NB; b++) begin
      for (int c = 0; c < 4; c++) begin
        n_vec++;
        if (tx_a !== exp_bits[b] || ready_a !== 1'b0) begin
          n_err++;
          $display("FAIL b2b01_bit%0d_cyc%0d: tx=%b ready=%b, required tx=%b ready=0",
                   b, c, tx_a, ready_a, exp_bits[b]);
        end
        @(negedge clk);
      end
    end
    n_vec++;
    if (tx_a !== 1'b1 || ready_a !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_gap: tx=%b ready=%b, required 1 1", tx_a, ready_a);
    end
    @(negedge clk);
    valid_a = 1'b0;
    data_a = 8'h00;
    if (P == 1) exp_bits = '{0,1,1,1,1,1,1,1,1,0,1};
    else        exp_bits = '{0,1,1,1,1,1,1,1,1,1,1};
    for (int b = 0; b < NB; b++) begin
      for (int c = 0; c < 4; c++) begin
        n_vec++;
        if (tx_a !== exp_bits[b] || ready_a !== 1'b0) begin
          n_err++;
          $display("FAIL b2bff_bit%0d_cyc%0d: tx=%b ready=%b, required tx=%b ready=0",
                   b, c, tx_a, ready_a, exp_bits[b]);
        end
        if (b == 4 && c == 1) data_a = 8'h5A;
        @(negedge clk);
      end
    end
    n_vec++;
    if (tx_a !== 1'b1 || ready_a !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_end: tx=%b ready=%b, required 1 1", tx_a, ready_a);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    exp_bits = '{0,1,0,1,0,1,0,1,0,1,1};
    data_a = 8'h55; valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    for (int c = 0; c < 18; c++) begin
      n_vec++;
      if (tx_a !== exp_bits[c/4]) begin
        n_err++;
        $display("FAIL f55_cyc%0d: tx=%b, required %b", c, tx_a, exp_bits[c/4]);
      end
      if (c < 17) @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      n_vec++;
      if (tx_a !== 1'b1 || ready_a !== 1'b1 || busy_a !== 1'b0) begin
        n_err++;
        $display("FAIL abort_idle%0d: tx=%b ready=%b busy=%b, required 1 1 0",
                 c, tx_a, ready_a, busy_a);
      end
      @(negedge clk);
    end
    if (P == 1) exp_bits = '{0,0,0,1,1,1,1,0,0,0,1};
    else        exp_bits = '{0,0,0,1,1,1,1,0,0,1,1};
    data_a = 8'h3C; valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    for (int b = 0; b < NB; b++) begin
      for (int c = 0; c < 4; c++) begin
        n_vec++;
        if (tx_a !== exp_bits[b] || ready_a !== 1'b0) begin
          n_err++;
          $display("FAIL f3c_bit%0d_cyc%0d: tx=%b ready=%b, required tx=%b ready=0",
                   b, c, tx_a, ready_a, exp_bits[b]);
        end
        @(negedge clk);
      end
    end
    n_vec++;
    if (tx_a !== 1'b1 || ready_a !== 1'b1) begin
      n_err++;
      $display("FAIL f3c_end: tx=%b ready=%b, required 1 1", tx_a, ready_a);
    end
    @(negedge clk);
  endtask

  task automatic test_bit_cycles_one();
    int nb_b;
    nb_b = 6 + P;
    if (P == 1) exp_bits = '{0,1,1,0,1,1,1,1,1,1,1};
    else        exp_bits = '{0,1,1,0,1,1,1,1,1,1,1};
    data_b = 4'hB; valid_b = 1'b1;
    @(negedge clk);
    valid_b = 1'b0;
    data_b = 4'h0;
    for (int b = 0; b < nb_b; b++) begin
      n_vec++;
      if (tx_b !== exp_bits[b] || ready_b !== 1'b0 || busy_b !== 1'b1) begin
        n_err++;
        $display("FAIL bc1_bit%0d: tx=%b ready=%b busy=%b, required tx=%b ready=0 busy=1",
                 b, tx_b, ready_b, busy_b, exp_bits[b]);
      end
      @(negedge clk);
    end
    n_vec++;
    if (tx_b !== 1'b1 || ready_b !== 1'b1 || busy_b !== 1'b0) begin
      n_err++;
      $display("FAIL bc1_end: tx=%b ready=%b busy=%b, required 1 1 0", tx_b, ready_b, busy_b);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_vs_valid();
    rst = 1'b1; data_a = 8'h81; valid_a = 1'b1;
    @(negedge clk);
    rst = 1'b0; valid_a = 1'b0;
    for (int c = 0; c < 6; c++) begin
      n_vec++;
      if (tx_a !== 1'b1 || ready_a !== 1'b1 || busy_a !== 1'b0) begin
        n_err++;
        $display("FAIL rst_valid_cyc%0d: tx=%b ready=%b busy=%b, required 1 1 0",
                 c, tx_a, ready_a, busy_a);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_frame_07();
    test_back_to_back();
    test_reset_mid_frame();
    test_bit_cycles_one();
    test_reset_vs_valid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
